// File: rtl/writeback_queue_pkg.sv
// Shared constants for the writeback queue: default widths and the
// hard-wired zero register index, which is never written and never forwarded.
package writeback_queue_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Writes to register 0 are architecturally discarded.
    localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/writeback_queue_match.sv
// Forwarding lookup over the pending-write entries. Entries are visited from
// the head (oldest) towards the tail (newest), so the last match seen is the
// newest pending value for the looked-up register.
module wbq_match
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [$clog2(DEPTH)-1:0]           head,
    input  logic [DEPTH-1:0]                   valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0]       tags,
    input  logic [DEPTH-1:0][DATA_W-1:0]       datas,
    input  logic [ADDR_W-1:0]                  lookup,
    output logic                               hit,
    output logic [DATA_W-1:0]                  data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Oldest-to-newest scan; a later match overrides an earlier one.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (valid[idx] && (tags[idx] == lookup)) begin
                hit  = 1'b1;
                data = datas[idx];
            end
        end
        if (lookup == ADDR_W'(ZERO_REG)) begin
            hit  = 1'b0;
            data = '0;
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: buffers producer results in a small circular queue and
// drains one per cycle to the register file unless stalled. Decode can look
// up pending writes for forwarding on two ports.
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_W-1:0]         in_reg,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      regwrite,
    output logic [ADDR_W-1:0]         write_reg,
    output logic [DATA_W-1:0]         write_data,
    input  logic                      stall,
    input  logic [ADDR_W-1:0]         lookup_reg_1,
    input  logic [ADDR_W-1:0]         lookup_reg_2,
    output logic                      hit_1,
    output logic                      hit_2,
    output logic [DATA_W-1:0]         fwd_data_1,
    output logic [DATA_W-1:0]         fwd_data_2,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]              rd_ptr;
    logic [PTR_W-1:0]              wr_ptr;
    logic [CNT_W-1:0]              cnt;
    logic [DEPTH-1:0]              ent_valid;
    logic [DEPTH-1:0][ADDR_W-1:0]  ent_reg;
    logic [DEPTH-1:0][DATA_W-1:0]  ent_data;

    logic drain;
    logic accept;
    logic push;
    logic m_hit_1;
    logic m_hit_2;
    logic [DATA_W-1:0] m_data_1;
    logic [DATA_W-1:0] m_data_2;

    // Handshake decode: drain frees the head this cycle, so a full queue can
    // still take a new result; zero-register results are accepted but not stored.
    assign drain    = !reset && (cnt != '0) && !stall;
    assign in_ready = !reset && ((cnt < FULL_CNT) || drain);
    assign accept   = in_valid && in_ready;
    assign push     = accept && (in_reg != ADDR_W'(ZERO_REG));

    // Register-file write port, zero when idle.
    assign regwrite   = drain;
    assign write_reg  = drain ? ent_reg[rd_ptr]  : '0;
    assign write_data = drain ? ent_data[rd_ptr] : '0;

    assign count = cnt;

    // Queue control state: pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            ent_valid <= '0;
        end else begin
            if (drain) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + PTR_W'(1);
            end
            // Placed after the drain clear: when full, push reuses the slot being freed.
            if (push) begin
                ent_valid[wr_ptr] <= 1'b1;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            case ({push, drain})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry payload storage, written on push.
    always_ff @(posedge clk) begin
        // NOTE: payload flops are not reset; the valid bits alone decide whether an entry is live.
        if (push) begin
            ent_reg[wr_ptr]  <= in_reg;
            ent_data[wr_ptr] <= in_data;
        end
    end

    wbq_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_match_1 (
        .head   (rd_ptr),
        .valid  (ent_valid),
        .tags   (ent_reg),
        .datas  (ent_data),
        .lookup (lookup_reg_1),
        .hit    (m_hit_1),
        .data   (m_data_1)
    );

    wbq_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_match_2 (
        .head   (rd_ptr),
        .valid  (ent_valid),
        .tags   (ent_reg),
        .datas  (ent_data),
        .lookup (lookup_reg_2),
        .hit    (m_hit_2),
        .data   (m_data_2)
    );

    // Lookups are silenced while reset is held, before the entries clear.
    assign hit_1      = !reset && m_hit_1;
    assign hit_2      = !reset && m_hit_2;
    assign fwd_data_1 = reset ? '0 : m_data_1;
    assign fwd_data_2 = reset ? '0 : m_data_2;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: inputs change 1 time unit after the
// rising edge, outputs are checked 1 unit later, well before the next edge.
module tb_writeback_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_reg;
    logic [31:0] in_data;
    logic        regwrite;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        stall;
    logic [4:0]  lookup_reg_1;
    logic [4:0]  lookup_reg_2;
    logic        hit_1;
    logic        hit_2;
    logic [31:0] fwd_data_1;
    logic [31:0] fwd_data_2;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_reg       (in_reg),
        .in_data      (in_data),
        .regwrite     (regwrite),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .stall        (stall),
        .lookup_reg_1 (lookup_reg_1),
        .lookup_reg_2 (lookup_reg_2),
        .hit_1        (hit_1),
        .hit_2        (hit_2),
        .fwd_data_1   (fwd_data_1),
        .fwd_data_2   (fwd_data_2),
        .count        (count)
    );

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Set the producer offer, then let combinational outputs settle.
    task automatic offer(input logic v, input logic [4:0] r, input logic [31:0] d);
        in_valid = v;
        in_reg   = r;
        in_data  = d;
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_reg       = '0;
        in_data      = '0;
        stall        = 1'b0;
        lookup_reg_1 = '0;
        lookup_reg_2 = '0;

        // Reset state
        step();
        offer(1'b1, 5'd9, 32'h99);
        check("rst_in_ready", in_ready, 0);
        check("rst_regwrite", regwrite, 0);
        check("rst_count", count, 0);
        step();
        reset = 1'b0;
        offer(1'b0, 5'd0, 32'h0);
        check("rst_rel_in_ready", in_ready, 1);
        check("rst_rel_count", count, 0);

        // Scenario 1: single write
        offer(1'b1, 5'd2, 32'h1);
        check("s1_in_ready", in_ready, 1);
        check("s1_no_early_write", regwrite, 0);
        step();
        offer(1'b0, 5'd0, 32'h0);
        check("s1_regwrite", regwrite, 1);
        check("s1_write_reg", write_reg, 2);
        check("s1_write_data", write_data, 1);
        check("s1_count_1", count, 1);
        step();
        check("s1_count_0", count, 0);
        check("s1_idle_regwrite", regwrite, 0);
        check("s1_idle_write_reg", write_reg, 0);
        check("s1_idle_write_data", write_data, 0);

        // Scenario 2: register-0 discard
        offer(1'b1, 5'd0, 32'hFFFF);
        check("s2_in_ready", in_ready, 1);
        step();
        offer(1'b0, 5'd0, 32'h0);
        check("s2_count", count, 0);
        check("s2_regwrite", regwrite, 0);
        step();
        check("s2_regwrite_later", regwrite, 0);

        // Scenario 3: fill under stall, then simultaneous accept and drain
        stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            offer(1'b1, 5'(i), 32'h10 + 32'(i));
            check($sformatf("s3_fill_ready_%0d", i), in_ready, 1);
            check("s3_fill_no_write", regwrite, 0);
            step();
        end
        offer(1'b1, 5'd5, 32'h15);
        check("s3_full_count", count, 4);
        check("s3_full_in_ready", in_ready, 0);
        stall = 1'b0;
        #1;
        check("s3_drain_in_ready", in_ready, 1);
        check("s3_drain_regwrite", regwrite, 1);
        check("s3_drain_reg_1", write_reg, 1);
        check("s3_drain_data_1", write_data, 32'h11);
        step();
        offer(1'b0, 5'd0, 32'h0);
        check("s3_count_held", count, 4);
        for (int i = 2; i <= 5; i++) begin
            check($sformatf("s3_order_rw_%0d", i), regwrite, 1);
            check($sformatf("s3_order_reg_%0d", i), write_reg, 32'(i));
            check($sformatf("s3_order_data_%0d", i), write_data, 32'h10 + 32'(i));
            step();
        end
        check("s3_empty_count", count, 0);
        check("s3_empty_regwrite", regwrite, 0);

        // Scenario 4: newest-wins forwarding; current offer is not forwarded
        stall        = 1'b1;
        lookup_reg_2 = 5'd9;
        offer(1'b1, 5'd9, 32'h9);
        check("s4_no_bypass_hit", hit_2, 0);
        check("s4_no_bypass_data", fwd_data_2, 0);
        offer(1'b1, 5'd7, 32'hA);
        step();
        offer(1'b1, 5'd7, 32'hB);
        step();
        offer(1'b0, 5'd0, 32'h0);
        lookup_reg_1 = 5'd7;
        lookup_reg_2 = 5'd0;
        #1;
        check("s4_hit_1", hit_1, 1);
        check("s4_fwd_1", fwd_data_1, 32'hB);
        check("s4_hit_2_zero", hit_2, 0);
        check("s4_fwd_2_zero", fwd_data_2, 0);
        stall = 1'b0;
        #1;
        check("s4_drain_a", write_data, 32'hA);
        check("s4_head_hit", hit_1, 1);
        check("s4_head_fwd", fwd_data_1, 32'hB);
        step();
        check("s4_drain_b", write_data, 32'hB);
        check("s4_last_hit", hit_1, 1);
        step();
        check("s4_gone_hit", hit_1, 0);
        check("s4_gone_fwd", fwd_data_1, 0);

        // Scenario 5: reset mid-operation
        stall = 1'b1;
        for (int i = 3; i <= 5; i++) begin
            offer(1'b1, 5'(i), 32'h50 + 32'(i));
            step();
        end
        offer(1'b0, 5'd0, 32'h0);
        lookup_reg_1 = 5'd3;
        #1;
        check("s5_pending_count", count, 3);
        check("s5_pending_hit", hit_1, 1);
        reset = 1'b1;
        stall = 1'b0;
        #1;
        check("s5_rst_regwrite", regwrite, 0);
        check("s5_rst_hit", hit_1, 0);
        check("s5_rst_in_ready", in_ready, 0);
        step();
        reset = 1'b0;
        #1;
        check("s5_count", count, 0);
        check("s5_hit_after", hit_1, 0);
        check("s5_in_ready", in_ready, 1);
        check("s5_regwrite_after", regwrite, 0);
        step();
        check("s5_regwrite_later", regwrite, 0);
        lookup_reg_1 = 5'd0;

        // Scenario 6: 20 back-to-back accepts through a wrapping queue
        stall = 1'b0;
        for (int i = 0; i < 20; i++) begin
            offer(1'b1, 5'((i % 31) + 1), 32'h100 + 32'(i));
            check($sformatf("s6_ready_%0d", i), in_ready, 1);
            check($sformatf("s6_count_%0d", i), count, (i == 0) ? 0 : 1);
            if (i > 0) begin
                check($sformatf("s6_rw_%0d", i), regwrite, 1);
                check($sformatf("s6_reg_%0d", i), write_reg, 32'(((i - 1) % 31) + 1));
                check($sformatf("s6_data_%0d", i), write_data, 32'h100 + 32'(i - 1));
            end
            step();
        end
        offer(1'b0, 5'd0, 32'h0);
        check("s6_last_rw", regwrite, 1);
        check("s6_last_reg", write_reg, 20);
        check("s6_last_data", write_data, 32'h113);
        step();
        check("s6_final_count", count, 0);
        check("s6_final_rw", regwrite, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
